// File: rtl/button_event_ctrl_pkg.sv
// Shared definitions for the button event controller: register addresses and
// the per-bit debounce state encoding.
package button_event_ctrl_pkg;

   localparam logic [1:0] ADDR_DATA     = 2'd0;
   localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
   localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } db_state_t;

endpackage

// File: rtl/button_debounce.sv
// One button channel: 2-flop synchronizer followed by a debounce FSM that
// accepts a new level only after it has held for DEBOUNCE_CYCLES clocks.
//
// state       | meaning
// ST_STABLE   | synchronized input matches the accepted level
// ST_COUNTING | input differs; counting how long it has held the new level
module button_debounce
   import button_event_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic in_raw,
   output logic level
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   db_state_t        state;
   db_state_t        state_nxt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic             level_q;
   logic             level_nxt;
   logic             differs;
   logic             done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= in_raw;
         sync_2 <= sync_1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_STABLE;
         count   <= '0;
         level_q <= 1'b0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         level_q <= level_nxt;
      end
   end

   assign differs = (sync_2 != level_q);
   assign done    = (count == CNT_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_STABLE:   if (differs) state_nxt = ST_COUNTING;
         ST_COUNTING: if (!differs || done) state_nxt = ST_STABLE;
         default:     state_nxt = ST_STABLE;
      endcase
   end

   // The cycle that moves STABLE->COUNTING counts as the first held cycle.
   always_comb begin
      count_nxt = count;
      level_nxt = level_q;
      case (state)
         ST_STABLE: count_nxt = differs ? CNT_ONE : '0;
         ST_COUNTING: begin
            if (!differs) begin
               count_nxt = '0;
            end else if (done) begin
               count_nxt = '0;
               level_nxt = ~level_q;
            end else begin
               count_nxt = count + CNT_ONE;
            end
         end
         default: count_nxt = '0;
      endcase
   end

   assign level = level_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Avalon-MM button controller: per-bit debounce, selectable-edge event
// capture with write-1-to-clear, and a masked level interrupt.
module button_event_ctrl
   import button_event_ctrl_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] level_d;
   logic [WIDTH-1:0] edge_sel;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] event_hit;
   logic [WIDTH-1:0] clr_mask;
   logic             wr_en;
   logic [31:0]      rd_mux;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_db
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
         .clk    (clk),
         .reset_n(reset_n),
         .in_raw (in_port[i]),
         .level  (level[i])
      );
   end

   assign unused_wdata = ^writedata[31:WIDTH];
   assign wr_en        = chipselect & ~write_n;

   // Events depend only on the debounced transition, so edge_sel changes never fire one.
   assign event_hit = (level & ~level_d & edge_sel) | (~level & level_d & ~edge_sel);
   assign clr_mask  = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;

   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:     rd_mux[WIDTH-1:0] = level;
         ADDR_EDGE_SEL: rd_mux[WIDTH-1:0] = edge_sel;
         ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
         ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap;
         default:       rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_d  <= '0;
         edge_sel <= '0;
         irq_mask <= '0;
         edge_cap <= '0;
         readdata <= '0;
      end else begin
         level_d  <= level;
         if (wr_en && address == ADDR_EDGE_SEL) edge_sel <= writedata[WIDTH-1:0];
         if (wr_en && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
         // A new event wins over a same-cycle clear.
         edge_cap <= (edge_cap & ~clr_mask) | event_hit;
         readdata <= rd_mux;
      end
   end

   assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl with WIDTH=4, DEBOUNCE_CYCLES=8.
module tb_button_event_ctrl;

   localparam int WIDTH = 4;
   localparam int DB    = 8;

   logic             clk;
   logic             reset_n;
   logic [1:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [WIDTH-1:0] in_port;
   logic [31:0]      readdata;
   logic             irq;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   button_event_ctrl #(
      .WIDTH          (WIDTH),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .in_port   (in_port),
      .readdata  (readdata),
      .irq       (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // readdata presented after the edge reflects the register state before it
   task automatic rd(input logic [1:0] a, input logic [31:0] e, input string tag);
      exp_t x;
      address = a;
      x.tag   = tag;
      x.val   = e;
      exp_q.push_back(x);
      tick();
      x = exp_q.pop_front();
      chk(x.tag, readdata, x.val);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;
      wait_cyc(3);
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      reset_n = 1'b1;
      rd(0, 32'h0, "rst_data");
      rd(1, 32'h0, "rst_edge_sel");
      rd(2, 32'h0, "rst_irq_mask");
      rd(3, 32'h0, "rst_edge_cap");

      // press bit 0, rising edge selected: data visible after 2+DB cycles plus read latency
      wr(1, 32'h1);
      in_port = 4'b0001;
      for (int i = 1; i <= DB + 2; i++) rd(0, 32'h0, "t1_data_pre");
      rd(0, 32'h1, "t1_data_post");
      wait_cyc(9);
      rd(3, 32'h1, "t1_cap");
      chk("t1_irq_masked", {31'b0, irq}, 32'h0);
      in_port = 4'b0000;
      wait_cyc(14);
      rd(0, 32'h0, "t1_data_rel");
      rd(3, 32'h1, "t1_cap_sticky");
      wr(3, 32'h1);
      rd(3, 32'h0, "t1_cap_clr");

      // bounce on bit 1: high 5, low 2, high 12
      wr(1, 32'h2);
      for (int e = 1; e <= 19; e++) begin
         in_port[1] = (e <= 5) || (e >= 8);
         rd(0, (e >= 18) ? 32'h2 : 32'h0, "t2_bounce");
      end
      in_port = 4'b0000;
      wait_cyc(14);
      rd(0, 32'h0, "t2_data_rel");
      rd(3, 32'h2, "t2_cap");
      wr(3, 32'h2);
      rd(3, 32'h0, "t2_cap_clr");

      // irq on bit 2 and its clear
      wr(2, 32'h4);
      wr(1, 32'h4);
      in_port = 4'b0100;
      wait_cyc(14);
      chk("t3_irq_set", {31'b0, irq}, 32'h1);
      rd(3, 32'h4, "t3_cap");
      wr(3, 32'h4);
      chk("t3_irq_clr", {31'b0, irq}, 32'h0);
      in_port = 4'b0000;
      wait_cyc(14);
      chk("t3_irq_rel", {31'b0, irq}, 32'h0);

      // event on bit 3 lands on the same edge as a W1C of bit 3
      wr(1, 32'h8);
      wr(2, 32'h8);
      in_port = 4'b1000;
      wait_cyc(DB + 2);
      wr(3, 32'h8);
      rd(3, 32'h8, "t4_cap_kept");
      chk("t4_irq", {31'b0, irq}, 32'h1);
      in_port = 4'b0000;
      wait_cyc(14);
      wr(3, 32'h8);
      rd(3, 32'h0, "t4_cap_clr");
      chk("t4_irq_clr", {31'b0, irq}, 32'h0);

      // falling edge selected: only the release captures
      wr(1, 32'h0);
      wr(2, 32'h0);
      in_port = 4'b0001;
      wait_cyc(14);
      rd(3, 32'h0, "t5_press");
      in_port = 4'b0000;
      wait_cyc(14);
      rd(3, 32'h1, "t5_release");
      wr(1, 32'hF);
      wait_cyc(2);
      rd(3, 32'h1, "t5_sel_change");
      rd(0, 32'h0, "t5_data");
      wr(3, 32'h1);
      rd(3, 32'h0, "t5_cap_clr");

      // reset mid-count (counter=5) with the button still held
      wr(1, 32'hF);
      wr(2, 32'hF);
      rd(1, 32'hF, "t6_sel_pre");
      in_port = 4'b0001;
      wait_cyc(7);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_readdata", readdata, 32'h0);
      chk("t6_rst_irq", {31'b0, irq}, 32'h0);
      wait_cyc(3);
      reset_n = 1'b1;
      rd(1, 32'h0, "t6_sel");
      rd(2, 32'h0, "t6_mask");
      rd(3, 32'h0, "t6_cap");
      for (int i = 4; i <= DB + 2; i++) rd(0, 32'h0, "t6_data_pre");
      rd(0, 32'h1, "t6_data_post");
      wait_cyc(3);
      rd(3, 32'h0, "t6_cap_after");
      chk("t6_irq", {31'b0, irq}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
